// File: rtl/datagram_frame_scheduler.sv
// datagram_frame_scheduler: arbitrates live/demo datagrams and commits them on frame boundaries
module datagram_frame_scheduler #(
  parameter int MESSAGE_SIZE   = 64,
  parameter int TIMEOUT_FRAMES = 120
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MESSAGE_SIZE-1:0] live_data,
  input  logic                    live_valid,
  output logic                    live_ready,
  input  logic [MESSAGE_SIZE-1:0] demo_data,
  input  logic                    demo_valid,
  output logic                    demo_ready,
  input  logic                    frame_start,
  output logic [MESSAGE_SIZE-1:0] datagram,
  output logic                    commit,
  output logic                    mode,
  output logic [7:0]              stale_frames
);
  localparam logic LIVE = 1'b0;
  localparam logic DEMO = 1'b1;
  localparam logic [7:0] limit = 8'(TIMEOUT_FRAMES);
  logic [MESSAGE_SIZE-1:0] pending;
  logic                    pending_valid;
  logic                    live_acc;
  logic                    demo_acc;
  logic                    bump;
  assign live_ready = rst;
  assign demo_ready = rst && (mode == DEMO) && !live_valid;
  // handshake decode and saturating frame-count enable
  always_comb begin
    live_acc = live_valid && live_ready;
    demo_acc = demo_valid && demo_ready;
    bump     = frame_start && (stale_frames != limit);
  end
  // pending buffer, frame-aligned commit, silence counter and mode FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      datagram      <= '0;
      commit        <= 1'b0;
      mode          <= LIVE;
      stale_frames  <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
    end else begin
      commit <= frame_start && pending_valid;
      if (frame_start && pending_valid) datagram <= pending;
      if (live_acc || demo_acc) begin
        pending       <= live_acc ? live_data : demo_data;
        pending_valid <= 1'b1;
      end else if (frame_start) begin
        pending_valid <= 1'b0;
      end
      stale_frames <= live_acc ? 8'd0 : bump ? stale_frames + 8'd1 : stale_frames;
      mode         <= live_acc ? LIVE : (bump && stale_frames + 8'd1 == limit) ? DEMO : mode;
    end
  end
endmodule

// File: tb/tb_datagram_frame_scheduler.sv
// tb_datagram_frame_scheduler: table vectors, directed corners and random traffic against a queue model
module tb_datagram_frame_scheduler;
  localparam int T = 4;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] live_data, demo_data, datagram;
  logic        live_valid, live_ready, demo_valid, demo_ready, frame_start, commit, mode;
  logic [7:0]  stale_frames;
  int checks = 0;
  int errors = 0;
  logic [63:0] m_dg;
  logic        m_commit;
  int          m_stale;
  logic [63:0] m_pq[$];

  datagram_frame_scheduler #(.MESSAGE_SIZE(64), .TIMEOUT_FRAMES(T)) dut (
    .clk(clk), .rst(rst),
    .live_data(live_data), .live_valid(live_valid), .live_ready(live_ready),
    .demo_data(demo_data), .demo_valid(demo_valid), .demo_ready(demo_ready),
    .frame_start(frame_start), .datagram(datagram), .commit(commit),
    .mode(mode), .stale_frames(stale_frames)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one clock: check readies before the edge, advance the model, check outputs after it
  task automatic cyc(input logic r, input logic lv, input logic [63:0] ld,
                     input logic dv, input logic [63:0] dd, input logic fs);
    logic la, da;
    rst = r; live_valid = lv; live_data = ld; demo_valid = dv; demo_data = dd; frame_start = fs;
    #1;
    chk("live_ready", 64'(live_ready), 64'(r));
    chk("demo_ready", 64'(demo_ready), 64'(r && m_stale == T && !lv));
    @(posedge clk);
    if (!r) begin
      m_dg = '0; m_commit = 1'b0; m_stale = 0; m_pq.delete();
    end else begin
      la = lv;
      da = dv && m_stale == T && !lv;
      m_commit = 1'b0;
      if (fs && m_pq.size() > 0) begin
        m_dg = m_pq.pop_front();
        m_commit = 1'b1;
      end
      if (la || da) begin
        m_pq.delete();
        m_pq.push_back(la ? ld : dd);
      end
      if (la) m_stale = 0;
      else if (fs && m_stale < T) m_stale++;
    end
    #1;
    chk("datagram", datagram, m_dg);
    chk("commit", 64'(commit), 64'(m_commit));
    chk("mode", 64'(mode), 64'(m_stale == T));
    chk("stale_frames", 64'(stale_frames), 64'(m_stale));
  endtask

  typedef struct {
    logic        r, lv;
    logic [63:0] ld;
    logic        dv;
    logic [63:0] dd;
    logic        fs;
    logic [63:0] e_dg;
    logic        e_c, e_m;
    logic [7:0]  e_s;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(logic r, logic lv, logic [63:0] ld, logic fs,
                             logic [63:0] dg, logic c, logic [7:0] s);
    vec_t x;
    x.r = r; x.lv = lv; x.ld = ld; x.dv = 1'b0; x.dd = '0; x.fs = fs;
    x.e_dg = dg; x.e_c = c; x.e_m = 1'b0; x.e_s = s;
    return x;
  endfunction

  initial begin
    m_dg = '0; m_commit = 1'b0; m_stale = 0;
    tbl.push_back(v(0, 1, 64'hAA, 0, 64'h00, 0, 0));
    tbl.push_back(v(0, 1, 64'hAA, 0, 64'h00, 0, 0));
    tbl.push_back(v(0, 1, 64'hAA, 0, 64'h00, 0, 0));
    tbl.push_back(v(1, 1, 64'hAA, 0, 64'h00, 0, 0));
    tbl.push_back(v(1, 0, 64'h00, 1, 64'hAA, 1, 1));
    tbl.push_back(v(1, 0, 64'h00, 0, 64'hAA, 0, 1));
    tbl.push_back(v(1, 1, 64'h11, 0, 64'hAA, 0, 0));
    tbl.push_back(v(1, 1, 64'h22, 0, 64'hAA, 0, 0));
    tbl.push_back(v(1, 0, 64'h00, 1, 64'h22, 1, 1));
    tbl.push_back(v(1, 0, 64'h00, 0, 64'h22, 0, 1));
    tbl.push_back(v(1, 0, 64'h00, 1, 64'h22, 0, 2));
    tbl.push_back(v(1, 1, 64'h33, 1, 64'h22, 0, 0));
    tbl.push_back(v(1, 0, 64'h00, 1, 64'h33, 1, 1));
    tbl.push_back(v(1, 0, 64'h00, 0, 64'h33, 0, 1));
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].lv, tbl[i].ld, tbl[i].dv, tbl[i].dd, tbl[i].fs);
      chk($sformatf("tbl%0d_dg", i), datagram, tbl[i].e_dg);
      chk($sformatf("tbl%0d_commit", i), 64'(commit), 64'(tbl[i].e_c));
      chk($sformatf("tbl%0d_mode", i), 64'(mode), 64'(tbl[i].e_m));
      chk($sformatf("tbl%0d_stale", i), 64'(stale_frames), 64'(tbl[i].e_s));
    end
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("to_stale3", 64'(stale_frames), 64'd3);
    chk("to_mode_live", 64'(mode), 64'd0);
    cyc(1, 0, 0, 0, 0, 1);
    chk("to_mode_demo", 64'(mode), 64'd1);
    chk("to_stale4", 64'(stale_frames), 64'd4);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("to_stale_sat", 64'(stale_frames), 64'd4);
    cyc(1, 0, 0, 1, 64'h44, 0);
    cyc(1, 0, 0, 0, 0, 1);
    chk("demo_dg", datagram, 64'h44);
    chk("demo_commit", 64'(commit), 64'd1);
    rst = 1'b1; live_valid = 1'b1; live_data = 64'h55; demo_valid = 1'b1; demo_data = 64'h66; frame_start = 1'b0;
    #1;
    chk("both_demo_ready", 64'(demo_ready), 64'd0);
    @(negedge clk);
    cyc(1, 1, 64'h55, 1, 64'h66, 0);
    chk("both_mode", 64'(mode), 64'd0);
    chk("both_stale", 64'(stale_frames), 64'd0);
    cyc(1, 0, 0, 0, 0, 1);
    chk("both_dg", datagram, 64'h55);
    cyc(1, 1, 64'h77, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    chk("rst_commit", 64'(commit), 64'd0);
    chk("rst_dg", datagram, 64'd0);
    for (int i = 0; i < 3000; i++) begin
      int lp;
      lp = ((i / 200) % 2 == 0) ? 4 : 64;
      cyc($urandom_range(0, 79) != 0, $urandom_range(0, lp - 1) == 0, {$urandom, $urandom},
          $urandom_range(0, 2) == 0, {$urandom, $urandom}, $urandom_range(0, 5) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
